alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
Initiator-side controller for the core's registered 16-bit ALU. It accepts one operation at a time from the decode/control stage over a valid/ready request channel. It drives the ALU op/operand inputs, waits out the ALU's registered result and zero-flag latency, and returns result, zero flag and error status over a valid/ready response channel. It also screens out illegal opcodes and zero divisors before they reach the ALU.

Parameters:
DATA_W, 16, operand/result width; must match the ALU.
OP_W, 3, opcode width.
CNT_W, 16, width of the issued-operation counter.

Ports:
i_clk  input  1  clock; all state updates on posedge.
i_rst_n  input  1  reset.
i_req_valid  input  1  request present.
o_req_ready  output  1  controller can accept a request.
i_req_op  input  OP_W  opcode: 1 add, 2 sub, 3 mul, 4 div, 5 mod.
i_req_a  input  DATA_W  operand A, routed to ALU in1.
i_req_b  input  DATA_W  operand B, routed to ALU in2.
o_rsp_valid  output  1  response present.
i_rsp_ready  input  1  consumer accepts response.
o_rsp_data  output  DATA_W  result.
o_rsp_z  output  1  zero flag.
o_rsp_err  output  1  1 = request rejected (illegal op or zero divisor).
o_alu_op  output  OP_W  to ALU opcode input.
o_alu_in1  output  DATA_W  to ALU in1.
o_alu_in2  output  DATA_W  to ALU in2.
i_alu_out  input  DATA_W  ALU registered result.
i_alu_z  input  1  ALU zero flag.
o_issue_cnt  output  CNT_W  count of operations actually sent to the ALU.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_n is synchronous, active-low.
- Reset values:
  - State is IDLE.
  - o_req_ready=1, o_rsp_valid=0, o_rsp_data=0, o_rsp_z=0, o_rsp_err=0.
  - o_alu_op=0, o_alu_in1=0, o_alu_in2=0, o_issue_cnt=0.
- Reset mid-operation aborts the operation and drops any pending response. o_alu_op returns to 0 in the same edge.
- ALU contract:
  - Result registers one edge after op/operands are sampled.
  - Zero flag registers one edge after the result, from the previous result.
  - Opcode 0 holds the ALU output.
  - sub = in2-in1, saturating to 0 when in2<=in1.
  - div/mod = in2 / in1 and in2 % in1.
- State machine: IDLE -> EXEC -> CAP_RES -> CAP_Z -> RESP -> IDLE.
- IDLE:
  - o_req_ready=1.
  - A handshake (valid&ready) latches op, a and b.
  - Op not in 1..5: go to RESP with data=0, z=0, err=1. ALU is not driven.
  - Op 4 or 5 with a==0: go to RESP with data=16'hFFFF, z=0, err=1. ALU is not driven.
  - Otherwise go to EXEC.
- EXEC (1 cycle):
  - o_alu_op=latched op, o_alu_in1=a, o_alu_in2=b.
  - o_issue_cnt increments at the end of this cycle; it wraps modulo 2^CNT_W.
- CAP_RES:
  - o_alu_op=0; operands hold their values.
  - Captures i_alu_out into o_rsp_data at the end of the cycle.
- CAP_Z: captures i_alu_z into o_rsp_z; err=0.
- RESP:
  - o_rsp_valid=1; data, z and err are stable until i_rsp_ready.
  - On handshake go to IDLE with o_rsp_valid=0 on the next cycle.
- o_req_ready=0 in every state except IDLE. There is no request/response overlap: one operation is in flight at most.
- Latency, from the accepting edge to o_rsp_valid high:
  - 4 cycles for a legal op.
  - 1 cycle for a rejected op.
- Results are DATA_W bits, truncated exactly as the ALU produces them (mul keeps the low 16 bits).

Optional Feature:
Macro ALU_ISSUE_LOCAL_Z_EN.
- Defined: CAP_Z is skipped. o_rsp_z = (captured result == 0), computed in CAP_RES. Legal-op latency becomes 3 cycles. i_alu_z is ignored.
- Undefined: i_alu_z is used as described above, with 4-cycle latency.

Decomposition:
- Package alu_pkg holds:
  - ALU opcode constants (ALU_NOP=0, ALU_ADD=1, ALU_SUB=2, ALU_MUL=3, ALU_DIV=4, ALU_MOD=5).
  - DATA_W and OP_W defaults.
  - The issue-state enum.
  - The divide-by-zero result constant 16'hFFFF.
- No sub-module; the FSM plus capture registers are a single module.

Test Plan:
- Reset, then op=1, a=3, b=4 -> response data=7, z=0, err=0 four cycles after accept; o_issue_cnt=1.
- op=2, a=9, b=5 (saturating case) -> data=0, z=1, err=0; o_alu_op is nonzero for exactly one cycle.
- op=4, a=0, b=10 -> response one cycle after accept with data=FFFF, err=1; o_alu_op stays 0; o_issue_cnt unchanged. Repeat with op=6 -> data=0, err=1.
- op=3, a=300, b=300 -> data=16'h5F90 (90000 mod 65536), z=0. Hold i_rsp_ready=0 for 5 cycles -> response stable and o_req_ready=0 throughout.
- Back-to-back ops 5(a=7, b=23)=2 then 1(a=0, b=0)=0 with i_rsp_ready=1 -> each response carries its own z (0, then 1), with no stale zero flag.
- Assert i_rst_n=0 during CAP_RES -> next cycle: IDLE, o_rsp_valid=0, o_alu_op=0; a following request completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, default widths,
// issue-state encoding and the divide-by-zero response value.
package alu_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned OP_W_DEF   = 3;

  localparam logic [OP_W_DEF-1:0] ALU_NOP = 3'd0;
  localparam logic [OP_W_DEF-1:0] ALU_ADD = 3'd1;
  localparam logic [OP_W_DEF-1:0] ALU_SUB = 3'd2;
  localparam logic [OP_W_DEF-1:0] ALU_MUL = 3'd3;
  localparam logic [OP_W_DEF-1:0] ALU_DIV = 3'd4;
  localparam logic [OP_W_DEF-1:0] ALU_MOD = 3'd5;

  // Response data returned when a div/mod request carries a zero divisor
  localparam logic [15:0] DIV0_RESULT = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXEC    = 3'd1,
    ST_CAP_RES = 3'd2,
    ST_CAP_Z   = 3'd3,
    ST_RESP    = 3'd4
  } issue_state_e;

endpackage

// File: rtl/alu_issue_ctrl.sv
// Initiator-side controller for the registered 16-bit ALU.
// Accepts one request at a time, screens illegal opcodes and zero divisors,
// drives the ALU for one cycle, waits out result and zero-flag latency and
// returns the response over a valid/ready channel.
// Optional build macro ALU_ISSUE_LOCAL_Z_EN: derive the zero flag locally from
// the captured result and skip the ALU zero-flag capture cycle.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned OP_W   = OP_W_DEF,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [OP_W-1:0]   i_req_op,
  input  logic [DATA_W-1:0] i_req_a,
  input  logic [DATA_W-1:0] i_req_b,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic              o_rsp_z,
  output logic              o_rsp_err,
  output logic [OP_W-1:0]   o_alu_op,
  output logic [DATA_W-1:0] o_alu_in1,
  output logic [DATA_W-1:0] o_alu_in2,
  input  logic [DATA_W-1:0] i_alu_out,
  input  logic              i_alu_z,
  output logic [CNT_W-1:0]  o_issue_cnt
);

  issue_state_e      state_q, state_d;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] in1_q, in2_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_z_q, rsp_err_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              op_legal, div_zero, reject;

  // Request screening: legal opcode range and zero divisor (divisor is in1 = a)
  always_comb begin
    op_legal = (i_req_op >= OP_W'(ALU_ADD)) && (i_req_op <= OP_W'(ALU_MOD));
    div_zero = ((i_req_op == OP_W'(ALU_DIV)) || (i_req_op == OP_W'(ALU_MOD)))
               && (i_req_a == '0);
    reject   = !op_legal || div_zero;
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state and handshake/ALU-drive outputs
  always_comb begin
    state_d     = state_q;
    o_req_ready = 1'b0;
    o_rsp_valid = 1'b0;
    o_alu_op    = '0;
    case (state_q)
      ST_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) state_d = reject ? ST_RESP : ST_EXEC;
      end
      ST_EXEC: begin
        o_alu_op = op_q;
        state_d  = ST_CAP_RES;
      end
      ST_CAP_RES: begin
`ifdef ALU_ISSUE_LOCAL_Z_EN
        state_d = ST_RESP;
`else
        state_d = ST_CAP_Z;
`endif
      end
      ST_CAP_Z: state_d = ST_RESP;
      ST_RESP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request latch, result/flag capture and issued-operation counter
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      op_q       <= '0;
      in1_q      <= '0;
      in2_q      <= '0;
      rsp_data_q <= '0;
      rsp_z_q    <= 1'b0;
      rsp_err_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_req_valid) begin
            if (!op_legal) begin
              rsp_data_q <= '0;
              rsp_z_q    <= 1'b0;
              rsp_err_q  <= 1'b1;
            end else if (div_zero) begin
              rsp_data_q <= DATA_W'(DIV0_RESULT);
              rsp_z_q    <= 1'b0;
              rsp_err_q  <= 1'b1;
            end else begin
              op_q      <= i_req_op;
              in1_q     <= i_req_a;
              in2_q     <= i_req_b;
              rsp_err_q <= 1'b0;
            end
          end
        end
        ST_EXEC: cnt_q <= cnt_q + 1'b1;
        ST_CAP_RES: begin
          rsp_data_q <= i_alu_out;
          rsp_err_q  <= 1'b0;
`ifdef ALU_ISSUE_LOCAL_Z_EN
          rsp_z_q    <= (i_alu_out == '0);
`endif
        end
        ST_CAP_Z: begin
          rsp_z_q   <= i_alu_z;
          rsp_err_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_alu_in1   = in1_q;
  assign o_alu_in2   = in2_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_z     = rsp_z_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_issue_cnt = cnt_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed vector table, reset-abort
// sequence and randomized requests against an arithmetic reference model.
module tb_alu_issue_ctrl;

`ifdef ALU_ISSUE_LOCAL_Z_EN
  localparam int LEGAL_LAT = 3;
`else
  localparam int LEGAL_LAT = 4;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [2:0]  req_op;
  logic [15:0] req_a, req_b;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_z, rsp_err;
  logic [2:0]  alu_op;
  logic [15:0] alu_in1, alu_in2;
  logic [15:0] alu_out = '0;
  logic        alu_z = 1'b1;
  logic [15:0] issue_cnt;

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] exp_cnt = '0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.DATA_W(16), .OP_W(3), .CNT_W(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_op(req_op), .i_req_a(req_a), .i_req_b(req_b),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_data(rsp_data), .o_rsp_z(rsp_z), .o_rsp_err(rsp_err),
    .o_alu_op(alu_op), .o_alu_in1(alu_in1), .o_alu_in2(alu_in2),
    .i_alu_out(alu_out), .i_alu_z(alu_z), .o_issue_cnt(issue_cnt)
  );

  // Registered ALU: result one edge after the op, zero flag one edge later
  always @(posedge clk) begin
    alu_z <= (alu_out == 16'd0);
    case (alu_op)
      3'd1: alu_out <= alu_in1 + alu_in2;
      3'd2: alu_out <= (alu_in2 > alu_in1) ? alu_in2 - alu_in1 : 16'd0;
      3'd3: alu_out <= alu_in1 * alu_in2;
      3'd4: alu_out <= alu_in2 / alu_in1;
      3'd5: alu_out <= alu_in2 % alu_in1;
      default: ;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] d, output logic z, output logic e,
                                output int lat);
    logic [31:0] p;
    e = (op == 3'd0) || (op > 3'd5) || (((op == 3'd4) || (op == 3'd5)) && (a == 16'd0));
    d = 16'd0;
    if (op == 3'd4 || op == 3'd5) d = 16'hFFFF;
    if (!e) begin
      p = 32'(a) * 32'(b);
      case (op)
        3'd1: d = 16'((32'(a) + 32'(b)) % 65536);
        3'd2: d = (b > a) ? 16'(int'(b) - int'(a)) : 16'd0;
        3'd3: d = p[15:0];
        3'd4: d = b / a;
        default: d = b % a;
      endcase
    end
    z   = !e && (d == 16'd0);
    lat = e ? 1 : LEGAL_LAT;
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input int hold, input logic [15:0] ed, input logic ez,
                        input logic ee, input int elat);
    int n, opcnt;
    logic got;
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    rsp_ready = (hold == 0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    if (!ee) exp_cnt = exp_cnt + 16'd1;
    n = 0; opcnt = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (alu_op != 3'd0) begin
        opcnt++;
        chk("alu_drive", {13'd0, alu_op, alu_in1}, {13'd0, op, a});
        chk("alu_in2", 32'(alu_in2), 32'(b));
      end
      if (!rsp_valid) chk("req_ready_busy", 32'(req_ready), 32'd0);
      got = rsp_valid;
    end
    if (!got) begin
      vectors++; miscompares++;
      $display("FAIL rsp_timeout: got no response expected response within 20 cycles");
      rsp_ready = 1'b0;
      return;
    end
    chk("latency", 32'(n), 32'(elat));
    chk("rsp_data", 32'(rsp_data), 32'(ed));
    chk("rsp_z", 32'(rsp_z), 32'(ez));
    chk("rsp_err", 32'(rsp_err), 32'(ee));
    chk("alu_op_cycles", 32'(opcnt), ee ? 32'd0 : 32'd1);
    chk("issue_cnt", 32'(issue_cnt), 32'(exp_cnt));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      chk("hold_data", {15'd0, rsp_z, rsp_data}, {15'd0, ez, ed});
      chk("hold_err", 32'(rsp_err), 32'(ee));
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("rsp_drop", 32'(rsp_valid), 32'd0);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a, b;
    int          hold;
    logic [15:0] d;
    logic        z, e;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [2:0]  rop;
    logic [15:0] ra, rb, md;
    logic        mz, me;
    int          ml;

    vecs[0] = '{3'd1, 16'd3,   16'd4,   1, 16'd7,      1'b0, 1'b0, LEGAL_LAT};
    vecs[1] = '{3'd2, 16'd9,   16'd5,   0, 16'd0,      1'b1, 1'b0, LEGAL_LAT};
    vecs[2] = '{3'd4, 16'd0,   16'd10,  0, 16'hFFFF,   1'b0, 1'b1, 1};
    vecs[3] = '{3'd6, 16'd2,   16'd10,  0, 16'd0,      1'b0, 1'b1, 1};
    vecs[4] = '{3'd3, 16'd300, 16'd300, 5, 16'h5F90,   1'b0, 1'b0, LEGAL_LAT};
    vecs[5] = '{3'd5, 16'd7,   16'd23,  0, 16'd2,      1'b0, 1'b0, LEGAL_LAT};
    vecs[6] = '{3'd1, 16'd0,   16'd0,   0, 16'd0,      1'b1, 1'b0, LEGAL_LAT};
    vecs[7] = '{3'd0, 16'd1,   16'd1,   0, 16'd0,      1'b0, 1'b1, 1};
    vecs[8] = '{3'd5, 16'd0,   16'd3,   2, 16'hFFFF,   1'b0, 1'b1, 1};
    vecs[9] = '{3'd7, 16'd5,   16'd5,   0, 16'd0,      1'b0, 1'b1, 1};

    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp", {15'd0, rsp_z, rsp_data}, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_alu", {13'd0, alu_op, alu_in1}, 32'd0);
    chk("rst_alu_in2", 32'(alu_in2), 32'd0);
    chk("rst_cnt", 32'(issue_cnt), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hold,
             vecs[i].d, vecs[i].z, vecs[i].e, vecs[i].lat);

    // Reset while the result is being captured aborts the operation
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd1; req_a = 16'd5; req_b = 16'd6;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("abort_exec_op", 32'(alu_op), 32'd1);
    @(negedge clk);
    chk("abort_in_cap_res", 32'(alu_op), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_alu_op", 32'(alu_op), 32'd0);
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    chk("abort_cnt", 32'(issue_cnt), 32'd0);
    rst_n = 1'b1;
    exp_cnt = '0;
    run_op(3'd1, 16'd10, 16'd20, 0, 16'd30, 1'b0, 1'b0, LEGAL_LAT);

    // Randomized requests against the reference model
    for (int i = 0; i < 150; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom);
      if ($urandom_range(0, 3) == 0) ra = 16'($urandom_range(0, 15));
      rb  = 16'($urandom);
      model(rop, ra, rb, md, mz, me, ml);
      run_op(rop, ra, rb, int'($urandom_range(0, 2)), md, mz, me, ml);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
